// File: rtl/pixel_readout_buffer.sv
// Captures Gray-coded pixel groups on READ_CLK_IN edges, decodes them into a group FIFO,
// and serializes them as a one-pixel-per-beat valid/ready stream with row/column and frame markers.
module pixel_readout_buffer #(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 8,
  parameter int FIFO_DEPTH             = 2
) (
  input  logic                                                 SYSTEM_CLK,
  input  logic                                                 SYSTEM_RESET,
  input  logic                                                 READ_RESET,
  input  logic                                                 READ_CLK_IN,
  input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0]          DATA_IN,
  output logic [BIT_DEPTH-1:0]                                 PIXEL_DATA,
  output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0]       PIXEL_ROW,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]         PIXEL_COL,
  output logic                                                 PIXEL_VALID,
  input  logic                                                 PIXEL_READY,
  output logic                                                 FRAME_START,
  output logic                                                 FRAME_END,
  output logic                                                 FRAME_DONE,
  output logic                                                 OVERFLOW
);
  localparam int OBPW = OUTPUT_BUS_PIXEL_WIDTH;
  localparam int BW   = OBPW * BIT_DEPTH;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int NG   = NPIX / OBPW;
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int KW   = (OBPW > 1) ? $clog2(OBPW) : 1;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_rclk_d;
  logic            w_edge;
  logic            w_capture_edge;
  logic [BW-1:0]   r_mem_data [FIFO_DEPTH];
  logic [GW-1:0]   r_mem_grp  [FIFO_DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [AW:0]     w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_drop;
  logic [GW-1:0]   r_grp;
  logic [BW-1:0]   r_ser_data;
  logic [GW-1:0]   r_ser_grp;
  logic [KW-1:0]   r_ser_k;
  logic            r_ser_valid;
  logic            w_accept;
  logic            w_last_accept;
  logic            w_drain_done;
  logic [IW-1:0]   w_idx;
  logic            r_overflow;
  logic            r_frame_done;
  logic [BW-1:0]   w_bin_group;

  function automatic logic [BIT_DEPTH-1:0] gray2bin(input logic [BIT_DEPTH-1:0] g);
    logic [BIT_DEPTH-1:0] b;
    b = '0;
    b[BIT_DEPTH-1] = g[BIT_DEPTH-1];
    for (int i = BIT_DEPTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    w_bin_group = '0;
    for (int k = 0; k < OBPW; k++)
      w_bin_group[k*BIT_DEPTH +: BIT_DEPTH] = gray2bin(DATA_IN[k*BIT_DEPTH +: BIT_DEPTH]);
  end

  // Handshake: a beat moves when PIXEL_VALID & PIXEL_READY; a valid beat stays put until then.
  assign w_edge         = READ_CLK_IN & ~r_rclk_d;
  assign w_count        = r_wptr - r_rptr;
  assign w_full         = (w_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty        = (w_count == '0);
  assign w_accept       = r_ser_valid & PIXEL_READY;
  assign w_last_accept  = w_accept & (r_ser_k == KW'(OBPW - 1));
  assign w_pop          = ~READ_RESET & ~w_empty & (~r_ser_valid | w_last_accept);
  assign w_capture_edge = (r_state == S_CAPTURE) & w_edge & ~READ_RESET;
  // Popping frees a slot in the same cycle, so a full FIFO still accepts the write.
  assign w_push         = w_capture_edge & (~w_full | w_pop);
  assign w_drop         = w_capture_edge & w_full & ~w_pop;
  assign w_drain_done   = (r_state == S_DRAIN) & ~READ_RESET & w_empty &
                          (~r_ser_valid | w_last_accept);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    w_state_next = S_IDLE;
      S_CAPTURE: if (w_capture_edge && r_grp == GW'(NG - 1)) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_drain_done) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (READ_RESET) w_state_next = S_CAPTURE;
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) r_state <= S_IDLE;
    else              r_state <= w_state_next;
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (w_push) begin
      r_mem_data[r_wptr[AW-1:0]] <= w_bin_group;
      r_mem_grp[r_wptr[AW-1:0]]  <= r_grp;
    end
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) begin
      r_rclk_d     <= 1'b0;
      r_frame_done <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_grp        <= '0;
      r_overflow   <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_ser_data   <= '0;
      r_ser_grp    <= '0;
      r_ser_k      <= '0;
    end else begin
      r_rclk_d     <= READ_CLK_IN;
      r_frame_done <= w_drain_done;
      if (READ_RESET) begin
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_grp       <= '0;
        r_overflow  <= 1'b0;
        r_ser_valid <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
        if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        // Dropped groups still advance the counter so later coordinates stay right.
        if (w_capture_edge) r_grp <= (r_grp == GW'(NG - 1)) ? '0 : r_grp + GW'(1);
        if (w_drop) r_overflow <= 1'b1;
        if (w_pop) begin
          r_ser_data  <= r_mem_data[r_rptr[AW-1:0]];
          r_ser_grp   <= r_mem_grp[r_rptr[AW-1:0]];
          r_ser_k     <= '0;
          r_ser_valid <= 1'b1;
        end else if (w_last_accept) begin
          r_ser_valid <= 1'b0;
        end else if (w_accept) begin
          r_ser_k <= r_ser_k + KW'(1);
        end
      end
    end
  end

  assign w_idx       = IW'(int'(r_ser_grp) * OBPW + int'(r_ser_k));
  assign PIXEL_DATA  = r_ser_data[r_ser_k*BIT_DEPTH +: BIT_DEPTH];
  assign PIXEL_ROW   = RW'(int'(w_idx) / WIDTH);
  assign PIXEL_COL   = CW'(int'(w_idx) % WIDTH);
  assign PIXEL_VALID = r_ser_valid;
  assign FRAME_START = r_ser_valid & (w_idx == '0);
  assign FRAME_END   = r_ser_valid & (w_idx == IW'(NPIX - 1));
  assign FRAME_DONE  = r_frame_done;
  assign OVERFLOW    = r_overflow;

endmodule
